// File: rtl/o_rescale_coef_unit_pkg.sv
// Shared types and helpers for the attention output-rescale coefficient engine.
//   coef_st_e   : engine FSM states
//   coef_mode_e : job mode (UPDATE / FIRST / NORM / reserved)
//   div_res_e   : per-row divider result selection
//   one_of()    : fixed-point 1.0 for a given number of fractional bits
//   exp_fx()    : fixed-point exp() for non-positive arguments
package mha_pkg;

    localparam int D_W_DEF  = 16;
    localparam int FRAC_DEF = 13;

    function automatic int one_of(input int frac);
        return 1 << frac;
    endfunction

    localparam int ONE = one_of(FRAC_DEF);

    typedef enum logic [2:0] {IDLE, EXP, MUL, DIV, OUT} coef_st_e;
    typedef enum logic [1:0] {M_UPD, M_FIRST, M_NORM, M_RSV} coef_mode_e;
    typedef enum logic [1:0] {R_CALC, R_SAT, R_ZERO} div_res_e;

    // exp(arg) with arg and result in Q.frac. Positive arguments clamp to 1.0.
    // Evaluated as 2^(arg*log2(e)): the integer part becomes a right shift and
    // the fraction uses a quadratic fit of 2^f on [0,1) (about 0.3% error).
    // Constants are stored in Q16 and scaled down to the requested frac (<=16).
    function automatic int exp_fx(input int arg, input int frac);
        int y;
        int k;
        int f;
        int p;
        int sh;
        if (arg >= 0) return 1 << frac;
        y  = (arg * (94548 >>> (16 - frac))) >>> frac;
        k  = y >>> frac;
        f  = y - (k << frac);
        p  = (1 << frac) + ((f * (43024 >>> (16 - frac))
             + ((f * f) >>> frac) * (22512 >>> (16 - frac))) >>> frac);
        sh = -k;
        if (sh >= 31) return 0;
        return p >>> sh;
    endfunction

endpackage

// File: rtl/o_rescale_coef_unit_if.sv
// Job/result bundle of the rescale coefficient engine.
//   I_VLD/O_RDY              : job handshake (mode + per-row stats)
//   I_MODE, I_MI_*, I_LI_*   : job payload, TIL rows of D_W bits
//   O_VLD/I_RDY              : result handshake
//   O_COEF, O_DZ             : per-row coefficient and divide-by-zero flag
// master = job source / result consumer, slave = engine.
interface o_rescale_coef_unit_if #(
    parameter int D_W = 16,
    parameter int TIL = 16
);
    logic                     I_VLD;
    logic                     O_RDY;
    logic [1:0]               I_MODE;
    logic [TIL-1:0][D_W-1:0]  I_MI_OLD;
    logic [TIL-1:0][D_W-1:0]  I_MI_NEW;
    logic [TIL-1:0][D_W-1:0]  I_LI_OLD;
    logic [TIL-1:0][D_W-1:0]  I_LI_NEW;
    logic                     O_VLD;
    logic                     I_RDY;
    logic [TIL-1:0][D_W-1:0]  O_COEF;
    logic [TIL-1:0]           O_DZ;

    modport master (
        output I_VLD, I_MODE, I_MI_OLD, I_MI_NEW, I_LI_OLD, I_LI_NEW, I_RDY,
        input  O_RDY, O_VLD, O_COEF, O_DZ
    );

    modport slave (
        input  I_VLD, I_MODE, I_MI_OLD, I_MI_NEW, I_LI_OLD, I_LI_NEW, I_RDY,
        output O_RDY, O_VLD, O_COEF, O_DZ
    );
endinterface

// File: rtl/o_rescale_coef_unit_div_row.sv
// One row's restoring divider: q = floor(num * 2^FRAC / den), bits FRAC..0,
// one bit per step. Saturating/zero/div-by-zero cases are resolved at start.
//   I_CLK, I_RST_N : clock, async active-low reset
//   start_i        : load num/den and resolve special cases
//   step_i         : produce the next quotient bit
//   first_i        : FIRST-mode job, result forced to 0 without DZ
//   num_i, den_i   : signed Q.FRAC operands
//   q_o            : quotient including the bit produced this cycle
//   dz_o           : den <= 0 seen at start
module o_coef_div_row
    import mha_pkg::*;
#(
    parameter int D_W  = 16,
    parameter int FRAC = 13
) (
    input  logic            I_CLK,
    input  logic            I_RST_N,
    input  logic            start_i,
    input  logic            step_i,
    input  logic            first_i,
    input  logic [D_W-1:0]  num_i,
    input  logic [D_W-1:0]  den_i,
    output logic [D_W-1:0]  q_o,
    output logic            dz_o
);
    localparam logic [D_W-1:0] ONE_W = D_W'(one_of(FRAC));

    div_res_e        res_q;
    logic [D_W:0]    rem_q;
    logic [D_W-1:0]  den_q;
    logic [D_W-1:0]  q_q;
    logic            dz_q;
    logic            ge;
    logic [D_W-1:0]  rem_sub;
    logic [D_W-1:0]  q_step;
    logic signed [D_W-1:0] num_s;
    logic signed [D_W-1:0] den_s;

    assign num_s   = $signed(num_i);
    assign den_s   = $signed(den_i);
    assign ge      = (rem_q >= {1'b0, den_q});
    // remainder stays below den (< 2^(D_W-1)), so D_W bits hold it before the shift
    assign rem_sub = ge ? D_W'(rem_q - {1'b0, den_q}) : rem_q[D_W-1:0];
    assign q_step  = (q_q << 1) | D_W'(ge);
    assign dz_o    = dz_q;

    always_comb begin
        q_o = q_step;
        case (res_q)
            R_SAT:   q_o = ONE_W;
            R_ZERO:  q_o = '0;
            default: q_o = q_step;
        endcase
    end

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            res_q <= R_ZERO;
            rem_q <= '0;
            den_q <= '0;
            q_q   <= '0;
            dz_q  <= 1'b0;
        end else if (start_i) begin
            rem_q <= {1'b0, num_i};
            den_q <= den_i;
            q_q   <= '0;
            dz_q  <= 1'b0;
            if (first_i)             res_q <= R_ZERO;
            else if (den_s <= 0) begin
                res_q <= R_SAT;
                dz_q  <= 1'b1;
            end
            else if (num_s >= den_s) res_q <= R_SAT;
            else if (num_s <= 0)     res_q <= R_ZERO;
            else                     res_q <= R_CALC;
        end else if (step_i) begin
            rem_q <= {rem_sub, 1'b0};
            q_q   <= q_step;
        end
    end
endmodule

// File: rtl/o_rescale_coef_unit.sv
// Per-row output-rescale coefficient engine for the tiled attention O accumulator.
// coef = exp(m_old-m_new)*l_old/l_new (UPDATE), 0 (FIRST/reserved), 1/l_new (NORM).
//   I_CLK, I_RST_N : clock, async active-low reset
//   I_CLR          : synchronous abort, back to IDLE, outputs keep last value
//   bus (slave)    : job handshake/payload in, coefficient handshake/result out
//
// state | meaning
// IDLE  | ready for a job, O_RDY=1
// EXP   | EXP_LAT cycles of per-row exp
// MUL   | num = e*l_old (mode muxed), dividers loaded
// DIV   | FRAC+1 divider iterations, shared counter
// OUT   | O_VLD=1, result held until I_RDY
module o_rescale_coef_unit
    import mha_pkg::*;
#(
    parameter int D_W     = 16,
    parameter int FRAC    = 13,
    parameter int TIL     = 16,
    parameter int EXP_LAT = 1
) (
    input  logic I_CLK,
    input  logic I_RST_N,
    input  logic I_CLR,
    o_rescale_coef_unit_if.slave bus
);
    localparam int CNT_W = $clog2(FRAC + EXP_LAT + 1);
    localparam logic [D_W-1:0] ONE_W = D_W'(one_of(FRAC));

    coef_st_e                state_q, state_d;
    coef_mode_e              mode_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [TIL-1:0][D_W-1:0] mi_old_q, mi_new_q, li_old_q, li_new_q;
    logic [TIL-1:0][D_W-1:0] e_q, e_d;
    logic [TIL-1:0][D_W-1:0] coef_q, q_row;
    logic [TIL-1:0]          dz_q, dz_row;
    logic                    is_first, div_start, div_step;

    assign bus.O_RDY  = (state_q == IDLE);
    assign bus.O_VLD  = (state_q == OUT);
    assign bus.O_COEF = coef_q;
    assign bus.O_DZ   = dz_q;

    assign is_first  = (mode_q == M_FIRST) || (mode_q == M_RSV);
    assign div_start = (state_q == MUL) && !I_CLR;
    assign div_step  = (state_q == DIV) && !I_CLR;

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (I_CLR) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (bus.I_VLD)     state_d = EXP;
                EXP:     if (cnt_q == '0)   state_d = MUL;
                MUL:                        state_d = DIV;
                DIV:     if (cnt_q == '0)   state_d = OUT;
                OUT:     if (bus.I_RDY)     state_d = IDLE;
                default:                    state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            mode_q   <= M_UPD;
            cnt_q    <= '0;
            mi_old_q <= '0;
            mi_new_q <= '0;
            li_old_q <= '0;
            li_new_q <= '0;
            e_q      <= '0;
            coef_q   <= '0;
            dz_q     <= '0;
        end else if (!I_CLR) begin
            case (state_q)
                IDLE: if (bus.I_VLD) begin
                    mode_q   <= coef_mode_e'(bus.I_MODE);
                    mi_old_q <= bus.I_MI_OLD;
                    mi_new_q <= bus.I_MI_NEW;
                    li_old_q <= bus.I_LI_OLD;
                    li_new_q <= bus.I_LI_NEW;
                    cnt_q    <= CNT_W'(EXP_LAT - 1);
                end
                EXP: begin
                    e_q   <= e_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                end
                MUL: cnt_q <= CNT_W'(FRAC);
                DIV: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    // the last iteration's bit is taken straight from the dividers
                    if (cnt_q == '0) begin
                        coef_q <= q_row;
                        dz_q   <= dz_row;
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar r = 0; r < TIL; r++) begin : g_row
        logic signed [D_W:0]     arg;
        logic signed [2*D_W-1:0] prod;
        logic [D_W-1:0]          num;

        assign arg      = $signed({mi_old_q[r][D_W-1], mi_old_q[r]})
                        - $signed({mi_new_q[r][D_W-1], mi_new_q[r]});
        assign e_d[r]   = D_W'(exp_fx(int'(arg), FRAC));
        assign prod     = $signed(e_q[r]) * $signed(li_old_q[r]);

        always_comb begin
            num = '0;
            case (mode_q)
                M_UPD:   num = D_W'(prod >>> FRAC);
                M_NORM:  num = ONE_W;
                default: num = '0;
            endcase
        end

        o_coef_div_row #(.D_W(D_W), .FRAC(FRAC)) u_div (
            .I_CLK   (I_CLK),
            .I_RST_N (I_RST_N),
            .start_i (div_start),
            .step_i  (div_step),
            .first_i (is_first),
            .num_i   (num),
            .den_i   (li_new_q[r]),
            .q_o     (q_row[r]),
            .dz_o    (dz_row[r])
        );
    end
endmodule
